// File: rtl/clk_sel_ctrl.sv
// Glitch-free sequencer for the 4:1 HDMI pixel-clock mux: gates the BUFGCE,
// switches the mux select, waits for MMCM lock, settles, then releases video reset.
module clk_sel_ctrl #(
    parameter logic [1:0]  DEFAULT_SEL   = 2'b00,
    parameter int unsigned GATE_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned RST_CYCLES    = 32,
    parameter int unsigned LOCK_TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_sel,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] lock,
    output logic [1:0] sel,
    output logic       clk_en,
    output logic       video_rst,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       lock_lost
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GATE_OFF  = 3'd1;
    localparam logic [2:0] S_SWITCH    = 3'd2;
    localparam logic [2:0] S_WAIT_LOCK = 3'd3;
    localparam logic [2:0] S_SETTLE    = 3'd4;
    localparam logic [2:0] S_RUN_RST   = 3'd5;

    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       target_q, target_d;
    logic [1:0]       prev_q, prev_d;
    logic [1:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;
    logic             done_q, done_d;
    logic             clk_en_q, clk_en_d;
    logic             video_rst_q, video_rst_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [3:0]       lock_meta_q, lock_s_q;
    logic             lock_cur;

    // Two-flop synchronizer for the asynchronous MMCM lock indications
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_q <= 4'b0000;
            lock_s_q    <= 4'b0000;
        end else begin
            lock_meta_q <= lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign lock_cur = lock_s_q[sel_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            target_q    <= DEFAULT_SEL;
            prev_q      <= DEFAULT_SEL;
            sel_q       <= DEFAULT_SEL;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
            done_q      <= 1'b0;
            clk_en_q    <= 1'b0;
            video_rst_q <= 1'b1;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            prev_q      <= prev_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
            done_q      <= done_d;
            clk_en_q    <= clk_en_d;
            video_rst_q <= video_rst_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        prev_d   = prev_q;
        sel_d    = sel_q;
        err_d    = err_q;
        lost_d   = lost_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Loss of the running source takes priority over a new request
                if (!lock_cur) begin
                    lost_d   = 1'b1;
                    target_d = sel_q;
                    prev_d   = sel_q;
                    cnt_d    = '0;
                    state_d  = S_GATE_OFF;
                end else if (req_valid) begin
                    if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = req_sel;
                        prev_d   = sel_q;
                        err_d    = 1'b0;
                        lost_d   = 1'b0;
                        cnt_d    = '0;
                        state_d  = S_GATE_OFF;
                    end
                end
            end
            S_GATE_OFF: begin
                if (cnt_q == GATE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SWITCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SWITCH: begin
                sel_d   = target_q;
                cnt_d   = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_cur) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (cnt_q == LOCK_LAST) begin
                    // Fall back to the previous source once; if that is also dead, park here
                    err_d = 1'b1;
                    if (sel_q != prev_q) begin
                        target_d = prev_q;
                        sel_d    = prev_q;
                        cnt_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (!lock_cur) begin
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN_RST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_WAIT_LOCK;
            end
        endcase

        // Outputs registered from the next state so they line up with state_q
        clk_en_d    = (state_d == S_IDLE) || (state_d == S_RUN_RST);
        video_rst_d = (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        ready_d     = (state_d == S_IDLE);
    end

    assign sel       = sel_q;
    assign clk_en    = clk_en_q;
    assign video_rst = video_rst_q;
    assign busy      = busy_q;
    assign req_ready = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl: table of switch requests plus hand-written
// startup, same-source, busy, lock-loss and mid-sequence reset sequences.
module tb_clk_sel_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_sel = 2'b00;
    logic       req_valid = 1'b0;
    logic [3:0] lock = 4'b0001;
    logic       req_ready;
    logic [1:0] sel;
    logic       clk_en;
    logic       video_rst;
    logic       busy;
    logic       done;
    logic       err;
    logic       lock_lost;

    int n_pass = 0;
    int n_total = 0;

    clk_sel_ctrl #(
        .DEFAULT_SEL  (2'b00),
        .GATE_CYCLES  (16),
        .SETTLE_CYCLES(64),
        .RST_CYCLES   (32),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_sel  (req_sel),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .lock     (lock),
        .sel      (sel),
        .clk_en   (clk_en),
        .video_rst(video_rst),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Watch every sel change: the clock must have been gated for at least 16 samples
    logic [1:0] sel_prev = 2'b00;
    int         gated = 0;
    int         mon_events = 0;
    int         mon_viol = 0;
    always @(posedge clk) begin
        #1;
        if (sel !== sel_prev) begin
            mon_events++;
            if (clk_en !== 1'b0 || gated < 16) mon_viol++;
        end
        gated    = (clk_en === 1'b0) ? gated + 1 : 0;
        sel_prev = sel;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return clk_en;
            1:       return video_rst;
            2:       return done;
            default: return lock_lost;
        endcase
    endfunction

    // Ticks until the chosen output equals val; n = ticks taken, or -1 on timeout
    task automatic wait_until(input int which, input logic val, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (sig(which) === val) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0] lk;
        logic [1:0] req;
        logic [1:0] exp_sel;
        logic       exp_err;
        int         en_lat;
        int         done_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int         n;
        logic [1:0] cur_sel;

        // lock, request, final sel, err, request->clk_en cycles, clk_en->done cycles
        vecs[0] = '{4'b0101, 2'b10, 2'b10, 1'b0, 82,  32};
        vecs[1] = '{4'b0111, 2'b01, 2'b01, 1'b0, 82,  32};
        vecs[2] = '{4'b0011, 2'b11, 2'b01, 1'b1, 182, 32};
        vecs[3] = '{4'b1011, 2'b11, 2'b11, 1'b0, 82,  32};
        vecs[4] = '{4'b1001, 2'b00, 2'b00, 1'b0, 82,  32};

        // Startup
        repeat (5) tick();
        chk("rst_sel", int'(sel), 0);
        chk("rst_clk_en", int'(clk_en), 0);
        chk("rst_video_rst", int'(video_rst), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_lock_lost", int'(lock_lost), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ready", int'(req_ready), 0);
        reset = 1'b0;
        wait_until(0, 1'b1, 200, n);
        chk("start_clk_en_lat", n, 67);
        chk("start_vrst_held", int'(video_rst), 1);
        wait_until(1, 1'b0, 100, n);
        chk("start_vrst_lat", n, 32);
        chk("start_done", int'(done), 1);
        tick();
        chk("start_done_pulse", int'(done), 0);
        chk("start_idle_busy", int'(busy), 0);
        chk("start_idle_ready", int'(req_ready), 1);
        cur_sel = 2'b00;

        // Table of switch requests
        for (int v = 0; v < 5; v++) begin
            lock = vecs[v].lk;
            repeat (3) tick();
            chk($sformatf("v%0d_sel_before", v), int'(sel), int'(cur_sel));
            req_sel   = vecs[v].req;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            chk($sformatf("v%0d_gate", v), int'(clk_en), 0);
            chk($sformatf("v%0d_busy", v), int'(busy), 1);
            repeat (16) tick();
            chk($sformatf("v%0d_sel_hold", v), int'(sel), int'(cur_sel));
            tick();
            chk($sformatf("v%0d_sel_switch", v), int'(sel), int'(vecs[v].req));
            chk($sformatf("v%0d_err_clear", v), int'(err), 0);
            wait_until(0, 1'b1, 300, n);
            chk($sformatf("v%0d_clk_en_lat", v), (n < 0) ? -1 : n + 17, vecs[v].en_lat);
            wait_until(1, 1'b0, 100, n);
            chk($sformatf("v%0d_done_lat", v), n, vecs[v].done_lat);
            chk($sformatf("v%0d_done", v), int'(done), 1);
            chk($sformatf("v%0d_sel_final", v), int'(sel), int'(vecs[v].exp_sel));
            chk($sformatf("v%0d_err", v), int'(err), int'(vecs[v].exp_err));
            cur_sel = vecs[v].exp_sel;
        end

        // Same-source request: immediate done, no gating
        req_sel   = 2'b00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("same_done", int'(done), 1);
        chk("same_busy", int'(busy), 0);
        chk("same_clk_en", int'(clk_en), 1);
        tick();
        chk("same_done_pulse", int'(done), 0);
        chk("same_sel", int'(sel), 0);

        // Request while busy is dropped
        lock = 4'b0101;
        repeat (3) tick();
        req_sel   = 2'b10;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (30) tick();
        chk("busy_ready_low", int'(req_ready), 0);
        req_sel   = 2'b01;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_until(1, 1'b0, 200, n);
        chk("busy_done_lat", n, 83);
        chk("busy_sel_final", int'(sel), 2);

        // Active source loses lock in IDLE
        lock = 4'b0001;
        wait_until(3, 1'b1, 20, n);
        chk("lost_lat", n, 3);
        chk("lost_gate", int'(clk_en), 0);
        chk("lost_sel", int'(sel), 2);
        lock = 4'b0101;
        wait_until(1, 1'b0, 200, n);
        chk("lost_done_lat", n, 114);
        chk("lost_done", int'(done), 1);
        chk("lost_sel_final", int'(sel), 2);
        chk("lost_err", int'(err), 0);
        tick();
        chk("lost_sticky", int'(lock_lost), 1);

        // Reset during SETTLE
        lock = 4'b0111;
        repeat (3) tick();
        req_sel   = 2'b01;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (40) tick();
        chk("mid_sel", int'(sel), 1);
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_sel", int'(sel), 0);
        chk("mid_rst_clk_en", int'(clk_en), 0);
        chk("mid_rst_vrst", int'(video_rst), 1);
        chk("mid_rst_lost", int'(lock_lost), 0);
        reset = 1'b0;
        wait_until(0, 1'b1, 200, n);
        chk("mid_clk_en_lat", n, 67);
        wait_until(1, 1'b0, 100, n);
        chk("mid_vrst_lat", n, 32);
        chk("mid_sel_final", int'(sel), 0);

        tick();
        chk("mon_sel_changes", mon_events, 9);
        chk("mon_gate_violations", mon_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
- Sequencing controller for the 4:1 pixel-clock select mux on the HDMI output path.
- Accepts a requested source (a/b/c/d clock) from the PS/GPIO side and changes the mux `sel` glitch-free: gate the output clock off, switch, wait for source MMCM lock, settle, then re-enable the clock with the downstream video reset held.
- Runs on the free-running control clock. Drives `sel` on the mux and the CE of the BUFGCE on `out_clk`.

Parameters:
- DEFAULT_SEL, 2'b00, source selected out of reset.
- GATE_CYCLES, 16, cycles clock held gated before `sel` changes.
- SETTLE_CYCLES, 64, cycles after lock before re-enabling clock.
- RST_CYCLES, 32, cycles `video_rst` stays high after `clk_en` rises.
- LOCK_TIMEOUT, 65535, max WAIT_LOCK cycles; 16-bit counter.

Ports:
- clk  in  1  control clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_sel  in  2  requested source: 00=a, 01=b, 10=c, 11=d.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- lock  in  4  per-source MMCM locked, asynchronous; bit i = source i.
- sel  out  2  to mux `sel`; registered.
- clk_en  out  1  BUFGCE CE for `out_clk`; registered.
- video_rst  out  1  reset to downstream timing/TMDS logic; registered.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- err  out  1  lock timeout occurred on last switch.
- lock_lost  out  1  sticky; the active source lost lock while IDLE.

Behaviour:
- Every `lock` bit passes through a 2-FF synchronizer (`lock_s`) before use. Interface is one clock, synchronous active-high reset; no other clock domains are used.
- Reset values:
  - `sel` = DEFAULT_SEL; `clk_en` = 0; `video_rst` = 1.
  - `err` = 0; `lock_lost` = 0; `done` = 0.
  - State = WAIT_LOCK, with target = prev = DEFAULT_SEL and counter = 0.
- States:
  - IDLE: `clk_en`=1, `video_rst`=0.
    - Accepts when `req_valid` is high.
    - If `req_sel` == `sel`: stay in IDLE and pulse `done` next cycle; no gating.
    - Otherwise: latch target=`req_sel`, prev=`sel`, clear `err` and `lock_lost` → GATE_OFF.
    - If `lock_s[sel]` falls: set `lock_lost`, target=prev=`sel` → GATE_OFF.
  - GATE_OFF: `clk_en`=0 and `video_rst`=1 from the first cycle. Hold GATE_CYCLES cycles → SWITCH.
  - SWITCH: one cycle; `sel` <= target → WAIT_LOCK.
  - WAIT_LOCK: count up each cycle.
    - `lock_s[sel]`=1 → SETTLE with counter cleared.
    - Counter == LOCK_TIMEOUT-1 without lock: set `err`, then:
      - if `sel` != prev: target=prev, `sel` <= prev, counter cleared, stay in WAIT_LOCK;
      - if `sel` == prev: stay in WAIT_LOCK indefinitely (counter saturates, `err` stays 1).
  - SETTLE: hold SETTLE_CYCLES cycles; restart the count if `lock_s[sel]` drops → RUN_RST.
  - RUN_RST: `clk_en`=1, `video_rst`=1 for RST_CYCLES cycles → IDLE.
    - `done` pulses in the cycle `video_rst` first reads 0.
- Boundaries:
  - `req_valid` while `busy`: ignored, not queued. Requester must hold until `req_ready`.
  - Reset mid-sequence: immediate return to reset values and state. `sel` jumps to DEFAULT_SEL with `clk_en`=0 in the same cycle.
  - `clk_en` and `sel` never change in the same cycle. `sel` only changes while `clk_en` has been 0 for at least GATE_CYCLES.

Test Plan:
- Startup: reset 5 cycles, `lock`=4'b0001 → `sel`=00; `clk_en` rises about 67 cycles after reset release; `video_rst` falls exactly 32 cycles later; one `done` pulse.
- Switch a→c, `lock`=4'b0101, `req_sel`=10 for 1 cycle in IDLE → `clk_en`=0 next cycle; `sel`=10 after 16 gated cycles; `clk_en`=1 after lock+64 cycles; `done` after 32 more; `err`=0.
- Same-source request: `req_sel`=`sel`=00 → `done` pulse next cycle; `clk_en` stays 1; `busy` stays 0.
- Timeout: request d with `lock[3]`=0, LOCK_TIMEOUT=100 → `err`=1 after 100 WAIT_LOCK cycles; `sel` reverts to prior value; sequence completes with `done`.
- Request while busy: second `req_valid` (`req_sel`=01) during SETTLE → ignored; final `sel` = first target.
- Lock loss and mid-switch reset:
  - drop `lock[sel]` in IDLE → `lock_lost`=1, re-gate/relock sequence, `sel` unchanged;
  - assert reset during SETTLE → next cycle `sel`=DEFAULT_SEL, `clk_en`=0, `video_rst`=1.
